// File: rtl/instr_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Shared definitions for the instruction issuer: opcode
//               encodings, instruction field bit positions and the FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

    // Opcodes (instr[15:12])
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_NOT  = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b1111;

    // Instruction field bit positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int TGT_MSB  = 11;
    localparam int TGT_LSB  = 8;
    localparam int SRC0_MSB = 7;
    localparam int SRC0_LSB = 4;
    localparam int SRC1_MSB = 3;
    localparam int SRC1_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Whole-word NOP driven whenever nothing is being issued
    localparam logic [15:0] INSTR_NOP = 16'h0000;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/instr_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_issuer_if
// Description : Bus bundle between the instruction issuer and its environment.
//               slave  : view taken by instr_issuer
//               master : view taken by the program loader / compute unit side
// Signals     : load_valid/load_ready/load_data - program-word write handshake
//               start/busy/done                 - run control and status
//               instr_out                       - instruction to compute unit
//               result_in                       - result byte from compute unit
//               result_data/result_valid        - captured result + pulse
//               checksum                        - XOR of captured results
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_issuer_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] instr_out;
    logic [7:0]  result_in;
    logic [7:0]  result_data;
    logic        result_valid;
    logic [7:0]  checksum;

    modport slave (
        input  load_valid, load_data, start, result_in,
        output load_ready, busy, done, instr_out, result_data, result_valid, checksum
    );

    modport master (
        output load_valid, load_data, start, result_in,
        input  load_ready, busy, done, instr_out, result_data, result_valid, checksum
    );
endinterface
`default_nettype wire

// File: rtl/instr_issuer_buffer.sv
`default_nettype none
// ============================================================================
// Module      : issue_buffer
// Description : Program memory, DEPTH x WIDTH, one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Ports       : clk   - clock
//               we    - write enable
//               waddr - write address
//               wdata - write data
//               raddr - read address
//               rdata - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module issue_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : instr_issuer
// Description : Loads a small program into issue_buffer, then on start issues
//               each word for exactly one cycle, waits RESULT_LAT cycles for
//               the compute unit's result, captures it and moves on. NOP is
//               driven on instr_out in every state except ISSUE.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               ena   - global enable; low freezes all state
//               bus   - instr_issuer_if.slave (load, run control, results)
// Config      : INSTR_ISSUER_CHECKSUM_EN - when defined, checksum accumulates
//               the XOR of every captured result; otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_issuer
    import instr_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int RESULT_LAT = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       ena,
    instr_issuer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
    localparam logic [WW-1:0] c_wait_init = WW'(RESULT_LAT - 1);

    state_t          r_state;
    logic [CW-1:0]   r_pc;
    logic [CW-1:0]   r_count;
    logic [WW-1:0]   r_wait;
    logic [7:0]      r_result_data;
    logic            r_result_valid;

    logic            w_load_fire;
    logic            w_start_fire;
    logic            w_capture;
    logic [15:0]     w_rdata;

    // A load accepted in the same cycle as start takes priority; start is dropped.
    assign w_load_fire  = (r_state == ST_IDLE) && bus.load_valid && (r_count < c_depth);
    assign w_start_fire = (r_state == ST_IDLE) && bus.start && !w_load_fire;
    assign w_capture    = (r_state == ST_WAIT) && (r_wait == '0);

    issue_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_buf (
        .clk   (clk),
        .we    (ena && w_load_fire),
        .waddr (r_count[AW-1:0]),
        .wdata (bus.load_data),
        .raddr (r_pc[AW-1:0]),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_pc           <= '0;
            r_count        <= '0;
            r_wait         <= '0;
            r_result_data  <= 8'h00;
            r_result_valid <= 1'b0;
        end else if (ena) begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load_fire) begin
                        r_count <= r_count + CW'(1);
                    end else if (w_start_fire) begin
                        r_pc    <= '0;
                        r_state <= (r_count == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wait  <= c_wait_init;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_result_data  <= bus.result_in;
                        r_result_valid <= 1'b1;
                        r_pc           <= r_pc + CW'(1);
                        r_state        <= (r_pc == r_count - CW'(1)) ? ST_DONE : ST_ISSUE;
                    end else begin
                        r_wait <= r_wait - WW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_ISSUER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 8'h00;
        end else if (ena) begin
            if (w_start_fire) begin
                r_checksum <= 8'h00;
            end else if (w_capture) begin
                r_checksum <= r_checksum ^ bus.result_in;
            end
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = 8'h00;
`endif

    // Outputs decode straight from state so reset takes effect immediately.
    assign bus.instr_out    = (r_state == ST_ISSUE) ? w_rdata : INSTR_NOP;
    assign bus.busy         = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign bus.done         = (r_state == ST_DONE);
    assign bus.load_ready   = (r_state == ST_IDLE) && (r_count < c_depth);
    assign bus.result_data  = r_result_data;
    assign bus.result_valid = r_result_valid;

endmodule
`default_nettype wire
